// File: rtl/unidade_controle_if.sv
// Control/status bundle between unidade_controle and the fluxo_dados side.
// slave  : the control unit (samples status, drives strobes and state code)
// master : the datapath / stimulus side
interface unidade_controle_if;
    logic       iniciar;
    logic       jogada_feita;
    logic       chavesIgualMemoria;
    logic       enderecoIgualSequencia;
    logic       fimS;
    logic       fimTMR;
    logic       timeout;

    logic       zeraR;
    logic       zeraE;
    logic       zeraS;
    logic       zeraM;
    logic       zeraTMR;
    logic       registraR;
    logic       registraM;
    logic       contaE;
    logic       contaS;
    logic       contaTMR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       db_timeout;
    logic [4:0] db_estado;

    modport slave (
        input  iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualSequencia,
               fimS, fimTMR, timeout,
        output zeraR, zeraE, zeraS, zeraM, zeraTMR, registraR, registraM,
               contaE, contaS, contaTMR, pronto, acertou, errou, db_timeout,
               db_estado
    );

    modport master (
        output iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualSequencia,
               fimS, fimTMR, timeout,
        input  zeraR, zeraE, zeraS, zeraM, zeraTMR, registraR, registraM,
               contaE, contaS, contaTMR, pronto, acertou, errou, db_timeout,
               db_estado
    );
endinterface

// File: rtl/unidade_controle.sv
// Moore control unit for the sequence-memory game datapath (fluxo_dados).
// Optional build macro: TIMEOUT_EN -- when defined, a timeout while waiting
// for a move ends the game in fim_timeout; otherwise timeout is ignored.
//
// state          | meaning
// inicial        | idle after reset, waits for iniciar
// preparacao     | clear all datapath registers/counters
// inicio_mostra  | clear display timer before the first item
// exibe          | show current ROM item until fimTMR
// apaga          | blank display, clear timer
// intervalo      | gap between items until fimTMR
// proximo_mostra | advance address, restart timer
// prepara_jogada | rewind address, clear play register
// espera_jogada  | wait for a move (or timeout)
// registra       | latch the player's move
// comparacao     | compare move against memory
// proximo        | advance to next expected move
// ultima_seq     | round complete, check for final round
// nova_seq       | grow the sequence, rewind address
// fim_acertou    | game won
// fim_errou      | game lost on a wrong move
// fim_timeout    | game lost on timeout
module unidade_controle (
    input  logic                 clock,
    input  logic                 reset,
    unidade_controle_if.slave    ctrl
);

    typedef enum logic [4:0] {
        inicial        = 5'h00,
        preparacao     = 5'h01,
        inicio_mostra  = 5'h02,
        exibe          = 5'h03,
        apaga          = 5'h04,
        intervalo      = 5'h05,
        proximo_mostra = 5'h06,
        prepara_jogada = 5'h07,
        espera_jogada  = 5'h08,
        registra       = 5'h09,
        comparacao     = 5'h0A,
        proximo        = 5'h0B,
        ultima_seq     = 5'h0C,
        nova_seq       = 5'h0D,
        fim_acertou    = 5'h0E,
        fim_errou      = 5'h0F,
        fim_timeout    = 5'h10
    } estado_t;

    estado_t estado;
    estado_t proximo_estado;

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) estado <= inicial;
        else        estado <= proximo_estado;
    end

    // Next-state logic; unused codes fall back to inicial
    always_comb begin
        proximo_estado = inicial;
        case (estado)
            inicial:        proximo_estado = ctrl.iniciar ? preparacao : inicial;
            preparacao:     proximo_estado = inicio_mostra;
            inicio_mostra:  proximo_estado = exibe;
            exibe:          proximo_estado = ctrl.fimTMR ? apaga : exibe;
            apaga:          proximo_estado = intervalo;
            intervalo: begin
                if (!ctrl.fimTMR)                    proximo_estado = intervalo;
                else if (ctrl.enderecoIgualSequencia) proximo_estado = prepara_jogada;
                else                                 proximo_estado = proximo_mostra;
            end
            proximo_mostra: proximo_estado = exibe;
            prepara_jogada: proximo_estado = espera_jogada;
            espera_jogada: begin
                // A move in the same cycle as a timeout takes priority.
                if (ctrl.jogada_feita) proximo_estado = registra;
`ifdef TIMEOUT_EN
                else if (ctrl.timeout) proximo_estado = fim_timeout;
`endif
                else                   proximo_estado = espera_jogada;
            end
            registra:       proximo_estado = comparacao;
            comparacao: begin
                if (!ctrl.chavesIgualMemoria)         proximo_estado = fim_errou;
                else if (ctrl.enderecoIgualSequencia) proximo_estado = ultima_seq;
                else                                  proximo_estado = proximo;
            end
            proximo:        proximo_estado = espera_jogada;
            ultima_seq:     proximo_estado = ctrl.fimS ? fim_acertou : nova_seq;
            nova_seq:       proximo_estado = inicio_mostra;
            fim_acertou:    proximo_estado = ctrl.iniciar ? preparacao : fim_acertou;
            fim_errou:      proximo_estado = ctrl.iniciar ? preparacao : fim_errou;
`ifdef TIMEOUT_EN
            fim_timeout:    proximo_estado = ctrl.iniciar ? preparacao : fim_timeout;
`endif
            default:        proximo_estado = inicial;
        endcase
    end

    // Moore output decode from the state register only
    always_comb begin
        ctrl.zeraR      = 1'b0;
        ctrl.zeraE      = 1'b0;
        ctrl.zeraS      = 1'b0;
        ctrl.zeraM      = 1'b0;
        ctrl.zeraTMR    = 1'b0;
        ctrl.registraR  = 1'b0;
        ctrl.registraM  = 1'b0;
        ctrl.contaE     = 1'b0;
        ctrl.contaS     = 1'b0;
        ctrl.contaTMR   = 1'b0;
        ctrl.pronto     = 1'b0;
        ctrl.acertou    = 1'b0;
        ctrl.errou      = 1'b0;
        ctrl.db_timeout = 1'b0;
        case (estado)
            preparacao: begin
                ctrl.zeraE   = 1'b1;
                ctrl.zeraS   = 1'b1;
                ctrl.zeraR   = 1'b1;
                ctrl.zeraM   = 1'b1;
                ctrl.zeraTMR = 1'b1;
            end
            inicio_mostra:  ctrl.zeraTMR = 1'b1;
            exibe: begin
                // registraM held for the whole state absorbs the sync-ROM latency.
                ctrl.registraM = 1'b1;
                ctrl.contaTMR  = 1'b1;
            end
            apaga: begin
                ctrl.zeraM   = 1'b1;
                ctrl.zeraTMR = 1'b1;
            end
            intervalo:      ctrl.contaTMR = 1'b1;
            proximo_mostra: begin
                ctrl.contaE  = 1'b1;
                ctrl.zeraTMR = 1'b1;
            end
            prepara_jogada: begin
                ctrl.zeraE = 1'b1;
                ctrl.zeraR = 1'b1;
            end
            registra:       ctrl.registraR = 1'b1;
            proximo:        ctrl.contaE = 1'b1;
            nova_seq: begin
                ctrl.contaS = 1'b1;
                ctrl.zeraE  = 1'b1;
            end
            fim_acertou: begin
                ctrl.pronto  = 1'b1;
                ctrl.acertou = 1'b1;
            end
            fim_errou: begin
                ctrl.pronto = 1'b1;
                ctrl.errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            fim_timeout: begin
                ctrl.pronto     = 1'b1;
                ctrl.errou      = 1'b1;
                ctrl.db_timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign ctrl.db_estado = estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: a stimulus table of per-edge
// inputs and expected next state, with expected outputs pushed to a
// scoreboard queue and popped one cycle later, plus a hand-written check
// that a held iniciar passes through preparacao exactly once.
module tb_unidade_controle;

    logic clock;
    logic reset;

    unidade_controle_if ifc ();

    unidade_controle dut (
        .clock (clock),
        .reset (reset),
        .ctrl  (ifc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        bit       rst;
        bit       ini;
        bit       jog;
        bit       chv;
        bit       eis;
        bit       fims;
        bit       ftmr;
        bit       tmo;
        logic [4:0] st;
    } vec_t;

    typedef struct {
        int          idx;
        logic [4:0]  st;
        logic [13:0] outs;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t v(bit rst, bit ini, bit jog, bit chv, bit eis,
                               bit fims, bit ftmr, bit tmo, logic [4:0] st);
        vec_t r;
        r.rst = rst; r.ini = ini; r.jog = jog; r.chv = chv; r.eis = eis;
        r.fims = fims; r.ftmr = ftmr; r.tmo = tmo; r.st = st;
        return r;
    endfunction

    // {zeraR,zeraE,zeraS,zeraM,zeraTMR, registraR,registraM,contaE,contaS,contaTMR,
    //  pronto,acertou,errou,db_timeout}
    function automatic logic [13:0] exp_outs(logic [4:0] st);
        case (st)
            5'h01: return 14'b11111_00000_0000;
            5'h02: return 14'b00001_00000_0000;
            5'h03: return 14'b00000_01001_0000;
            5'h04: return 14'b00011_00000_0000;
            5'h05: return 14'b00000_00001_0000;
            5'h06: return 14'b00001_00100_0000;
            5'h07: return 14'b11000_00000_0000;
            5'h09: return 14'b00000_10000_0000;
            5'h0B: return 14'b00000_00100_0000;
            5'h0D: return 14'b01000_00010_0000;
            5'h0E: return 14'b00000_00000_1100;
            5'h0F: return 14'b00000_00000_1010;
            5'h10: return 14'b00000_00000_1011;
            default: return 14'b0;
        endcase
    endfunction

    function automatic logic [13:0] act_outs();
        return {ifc.zeraR, ifc.zeraE, ifc.zeraS, ifc.zeraM, ifc.zeraTMR,
                ifc.registraR, ifc.registraM, ifc.contaE, ifc.contaS, ifc.contaTMR,
                ifc.pronto, ifc.acertou, ifc.errou, ifc.db_timeout};
    endfunction

    task automatic drive(vec_t x);
        reset                      = x.rst;
        ifc.iniciar                = x.ini;
        ifc.jogada_feita           = x.jog;
        ifc.chavesIgualMemoria     = x.chv;
        ifc.enderecoIgualSequencia = x.eis;
        ifc.fimS                   = x.fims;
        ifc.fimTMR                 = x.ftmr;
        ifc.timeout                = x.tmo;
    endtask

    task automatic check_pop();
        exp_t e;
        logic [13:0] a;
        e = sb.pop_front();
        a = act_outs();
        n_vec++;
        if (ifc.db_estado !== e.st || a !== e.outs) begin
            n_err++;
            $display("FAIL vec%0d: db_estado got %h want %h, outputs got %b want %b",
                     e.idx, ifc.db_estado, e.st, a, e.outs);
        end
    endtask

    task automatic apply(int idx, vec_t x);
        exp_t e;
        drive(x);
        e.idx  = idx;
        e.st   = x.st;
        e.outs = exp_outs(x.st);
        sb.push_back(e);
        @(posedge clock);
        #1;
        check_pop();
    endtask

    logic [4:0] st_to;
    logic [4:0] st_after;

    initial begin
`ifdef TIMEOUT_EN
        st_to    = 5'h10;
        st_after = 5'h01;
`else
        st_to    = 5'h08;
        st_after = 5'h08;
`endif
        //            rst ini jog chv eis fms ftm tmo  state
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 5'h00));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 5'h00));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 5'h01));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h02));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h03));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h03));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 5'h04));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h05));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0, 5'h05));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 0, 5'h07));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h08));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h08));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 1, 5'h09));
        tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 0, 5'h0A));
        tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 0, 5'h0C));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h0D));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h02));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h03));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 5'h04));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h05));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 5'h06));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 5'h03));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 5'h04));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h05));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 0, 5'h07));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h08));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 5'h09));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h0A));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 5'h0B));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h08));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 5'h09));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h0A));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0, 5'h0F));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h0F));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 5'h01));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h02));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h03));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 5'h04));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h05));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 0, 5'h07));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h08));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 5'h09));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h0A));
        tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 0, 5'h0C));
        tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 5'h0E));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h0E));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 5'h01));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h02));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h03));
        tbl.push_back(v(0, 1, 1, 1, 1, 1, 1, 1, 5'h00));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h00));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 5'h01));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h02));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h03));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 5'h04));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h05));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 0, 5'h07));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5'h08));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, st_to));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, st_after));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 5'h00));

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // iniciar held high through a whole display round: preparacao must
        // be visited once and the FSM must settle in espera_jogada.
        begin
            int n_prep = 0;
            bit reached = 0;
            drive(v(1, 1, 0, 0, 1, 0, 1, 0, 5'h00));
            for (int c = 0; c < 20 && !reached; c++) begin
                @(posedge clock);
                #1;
                if (ifc.db_estado == 5'h01) n_prep++;
                if (ifc.db_estado == 5'h08) reached = 1;
            end
            n_vec++;
            if (!reached) begin
                n_err++;
                $display("FAIL held_iniciar_reach: db_estado got %h want 08 within 20 cycles",
                         ifc.db_estado);
            end
            n_vec++;
            if (n_prep != 1) begin
                n_err++;
                $display("FAIL held_iniciar_prep_once: preparacao visits got %0d want 1", n_prep);
            end
            for (int c = 0; c < 3; c++) begin
                @(posedge clock);
                #1;
                n_vec++;
                if (ifc.db_estado !== 5'h08) begin
                    n_err++;
                    $display("FAIL held_iniciar_hold%0d: db_estado got %h want 08",
                             c, ifc.db_estado);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
